struct_rec_assembler: RTL and testbench

//  Byte-stream deserializer feeding the packed-struct consumer stage. Collects 5 bytes
//  per record into packed rec_t (33 b), then presents it on a valid/ready output.
//  rec_t is declared in package rec_pkg as

---
 rtl/struct_rec_assembler_if.sv | 60 ++++++
 rtl/struct_rec_assembler.sv | 142 ++++++++++++++
 tb/tb_struct_rec_assembler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/struct_rec_assembler_if.sv
// Record type shared by the assembler and its consumer, plus the stream/record
// handshake bundle that connects the assembler to its neighbours.

package rec_pkg;

  // Two-byte payload tail of a record.
  typedef struct packed {
    byte a;
    byte b;
  } p_t;

  // 33-bit assembled record: a=[32], b=[31:24], t=[23:16], ps.a=[15:8], ps.b=[7:0].
  typedef struct packed {
    bit          a;
    logic [7:0]  b;
    logic [7:0]  t;
    p_t          ps;
  } rec_t;

endpackage

// Byte stream in, record stream out, plus error pulse and delivery counter.
interface struct_rec_assembler_if #(
  parameter int unsigned CNT_W = 16
);

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  rec_pkg::rec_t      out_rec;
  logic               out_valid;
  logic               out_ready;
  logic               err;
  logic [CNT_W-1:0]   rec_count;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_rec,
    input  out_valid,
    output out_ready,
    input  err,
    input  rec_count
  );

  // Assembler side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_rec,
    output out_valid,
    input  out_ready,
    output err,
    output rec_count
  );

endinterface

// File: rtl/struct_rec_assembler.sv
// Byte-stream deserializer: gathers five bytes per record into a packed rec_t,
// drops records with a bad tag or an inter-byte timeout, and offers complete
// records on a valid/ready output.

module struct_rec_assembler #(
  parameter logic [6:0]  TAG     = 7'h2A,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  struct_rec_assembler_if.slave   bus
);

  localparam logic [0:0]  S_COLLECT = 1'b0;
  localparam logic [0:0]  S_HOLD    = 1'b1;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Idle value at which one more empty cycle makes the gap reach TIMEOUT.
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

  logic [0:0]          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_tag_ok;
  rec_pkg::rec_t       r_shadow;
  rec_pkg::rec_t       r_out_rec;
  logic                r_out_valid;
  logic                r_err;
  logic [CNT_W-1:0]    r_count;

  logic [0:0]          w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [IDLE_W-1:0]   w_idle_nxt;
  logic                w_tag_ok_nxt;
  rec_pkg::rec_t       w_shadow_nxt;
  rec_pkg::rec_t       w_out_rec_nxt;
  logic                w_out_valid_nxt;
  logic                w_err_nxt;
  logic [CNT_W-1:0]    w_count_nxt;

  logic                w_accept;
  logic                w_out_hs;

  assign w_accept = bus.in_valid && (r_state == S_COLLECT);
  assign w_out_hs = r_out_valid && bus.out_ready;

  // Next-state and next-output decode for collection, timeout and hand-off.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_idle_nxt      = r_idle;
    w_tag_ok_nxt    = r_tag_ok;
    w_shadow_nxt    = r_shadow;
    w_out_rec_nxt   = r_out_rec;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;
    w_count_nxt     = r_count;

    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          // An accepted byte always wins over a coinciding timeout.
          w_idle_nxt = '0;
          w_idx_nxt  = r_idx + IDX_W'(1);
          case (r_idx)
            3'd0: begin
              w_tag_ok_nxt   = (bus.in_data[7:1] == TAG);
              w_shadow_nxt.a = bus.in_data[0];
            end
            3'd1: w_shadow_nxt.b    = bus.in_data;
            3'd2: w_shadow_nxt.t    = bus.in_data;
            3'd3: w_shadow_nxt.ps.a = bus.in_data;
            default: begin
              // Fifth byte closes the frame whether or not the tag matched.
              w_idx_nxt          = '0;
              w_shadow_nxt.ps.b  = bus.in_data;
              if (r_tag_ok) begin
                w_out_rec_nxt   = w_shadow_nxt;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_HOLD;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
          endcase
        end else if ((TIMEOUT > 0) && (r_idx != '0)) begin
          // Gap inside a record: abandon the partial record once it hits TIMEOUT.
          if (r_idle == IDLE_LAST) begin
            w_err_nxt  = 1'b1;
            w_idx_nxt  = '0;
            w_idle_nxt = '0;
          end else begin
            w_idle_nxt = r_idle + IDLE_W'(1);
          end
        end
      end
      default: begin
        // HOLD: record parked on the output until the consumer takes it.
        if (w_out_hs) begin
          w_out_valid_nxt = 1'b0;
          w_count_nxt     = r_count + CNT_W'(1);
          w_state_nxt     = S_COLLECT;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_idx       <= '0;
      r_idle      <= '0;
      r_tag_ok    <= 1'b0;
      r_shadow    <= '0;
      r_out_rec   <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_idle      <= w_idle_nxt;
      r_tag_ok    <= w_tag_ok_nxt;
      r_shadow    <= w_shadow_nxt;
      r_out_rec   <= w_out_rec_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
      r_count     <= w_count_nxt;
    end
  end

  // in_ready is a pure decode of the state register, independent of out_ready.
  assign bus.in_ready  = (r_state == S_COLLECT);
  assign bus.out_rec   = r_out_rec;
  assign bus.out_valid = r_out_valid;
  assign bus.err       = r_err;
  assign bus.rec_count = r_count;

endmodule

// File: tb/tb_struct_rec_assembler.sv
// Bench for struct_rec_assembler: constant record table, hand-written corner
// sequences and a random phase, all cross-checked against a byte-queue model.

module tb_struct_rec_assembler;

  localparam int unsigned TB_CNT_W   = 4;
  localparam int unsigned TB_TIMEOUT = 16;
  localparam logic [6:0]  TB_TAG     = 7'h2A;
  localparam logic [32:0] REC1       = 33'h1_1155AA55;
  localparam logic [32:0] REC2       = 33'h0_DEADBEEF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  struct_rec_assembler_if #(.CNT_W(TB_CNT_W)) bus ();

  struct_rec_assembler #(
    .TAG     (TB_TAG),
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes of the current partial record, held record, counters.
  logic [7:0]          m_q[$];
  bit                  m_hold;
  logic [32:0]         m_rec;
  logic [TB_CNT_W-1:0] m_cnt;
  int unsigned         m_idle;
  bit                  m_err;

  typedef struct {
    logic [39:0] bytes;
    bit          ok;
    logic [32:0] rec;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_hold = 1'b0;
    m_rec  = '0;
    m_cnt  = '0;
    m_idle = 0;
    m_err  = 1'b0;
  endtask

  // One clock of model behaviour given the inputs presented before the edge.
  task automatic m_step(input logic [7:0] d, input bit v, input bit r);
    logic [7:0] b0;
    m_err = 1'b0;
    if (m_hold) begin
      if (r) begin
        m_hold = 1'b0;
        m_cnt  = m_cnt + TB_CNT_W'(1);
      end
    end else if (v) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == 5) begin
        b0 = m_q[0];
        if (b0[7:1] == TB_TAG) begin
          m_rec  = {b0[0], m_q[1], m_q[2], m_q[3], m_q[4]};
          m_hold = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_q.delete();
      end
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == TB_TIMEOUT) begin
        m_err  = 1'b1;
        m_idle = 0;
        m_q.delete();
      end
    end
  endtask

  // Drive one cycle, advance the model, compare every output after the edge.
  task automatic step(input logic [7:0] d, input bit v, input bit r);
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = r;
    m_step(d, v, r);
    @(posedge clk);
    #1;
    chk("cyc_out_valid", 64'(bus.out_valid), 64'(m_hold));
    chk("cyc_in_ready",  64'(bus.in_ready),  64'(!m_hold));
    chk("cyc_err",       64'(bus.err),       64'(m_err));
    chk("cyc_rec_count", 64'(bus.rec_count), 64'(m_cnt));
    chk("cyc_out_rec",   64'(bus.out_rec),   64'(m_rec));
  endtask

  task automatic send_rec(input logic [39:0] bytes, input bit r);
    for (int k = 0; k < 5; k++) begin
      step(bytes[39 - 8*k -: 8], 1'b1, r);
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TB_CNT_W-1:0] exp_cnt;
    int unsigned         pv;
    logic [7:0]          d;

    vecs[0] = '{40'h55_11_55_AA_55, 1'b1, REC1};
    vecs[1] = '{40'h54_DE_AD_BE_EF, 1'b1, REC2};
    vecs[2] = '{40'h00_01_02_03_04, 1'b0, 33'h0};
    vecs[3] = '{40'h2A_FF_FF_FF_FF, 1'b0, 33'h0};
    vecs[4] = '{40'h55_00_00_00_00, 1'b1, 33'h1_00000000};
    vecs[5] = '{40'h54_80_7F_01_FE, 1'b1, 33'h0_807F01FE};
    vecs[6] = '{40'hD5_12_34_56_78, 1'b0, 33'h0};

    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_rec",   64'(bus.out_rec),   64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);
    chk("rst_rec_count", 64'(bus.rec_count), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    rst = 1'b0;

    // Table of back-to-back records with out_ready tied high.
    exp_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      send_rec(vecs[i].bytes, 1'b1);
      chk("tbl_valid", 64'(bus.out_valid), 64'(vecs[i].ok));
      chk("tbl_err",   64'(bus.err),       64'(!vecs[i].ok));
      if (vecs[i].ok) begin
        chk("tbl_rec", 64'(bus.out_rec), 64'(vecs[i].rec));
        exp_cnt = exp_cnt + TB_CNT_W'(1);
      end
      step(8'h00, 1'b0, 1'b1);
      chk("tbl_err_clr", 64'(bus.err),       64'd0);
      chk("tbl_valid0",  64'(bus.out_valid), 64'd0);
      chk("tbl_cnt",     64'(bus.rec_count), 64'(exp_cnt));
    end

    // Back-pressure: record parked for 10 cycles while junk bytes are offered.
    send_rec(40'h55_11_55_AA_55, 1'b0);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",   64'(bus.in_ready),  64'd0);
      chk("bp_rec",        64'(bus.out_rec),   64'(REC1));
    end
    step(8'h00, 1'b0, 1'b1);
    exp_cnt = exp_cnt + TB_CNT_W'(1);
    chk("bp_in_ready_up", 64'(bus.in_ready),  64'd1);
    chk("bp_cnt",         64'(bus.rec_count), 64'(exp_cnt));

    // Timeout: a 16-cycle gap drops the partial record.
    step(8'h55, 1'b1, 1'b1);
    step(8'h11, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(8'h00, 1'b0, 1'b1);
      chk("to_no_err", 64'(bus.err), 64'd0);
    end
    step(8'h00, 1'b0, 1'b1);
    chk("to_err", 64'(bus.err), 64'd1);
    step(8'h00, 1'b0, 1'b1);
    chk("to_err_pulse", 64'(bus.err), 64'd0);

    // A 15-cycle gap is tolerated and the record completes.
    step(8'h55, 1'b1, 1'b1);
    step(8'h11, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(8'h00, 1'b0, 1'b1);
    step(8'h55, 1'b1, 1'b1);
    step(8'hAA, 1'b1, 1'b1);
    step(8'h55, 1'b1, 1'b1);
    chk("gap15_valid", 64'(bus.out_valid), 64'd1);
    chk("gap15_rec",   64'(bus.out_rec),   64'(REC1));
    step(8'h00, 1'b0, 1'b1);
    exp_cnt = exp_cnt + TB_CNT_W'(1);
    chk("gap15_cnt", 64'(bus.rec_count), 64'(exp_cnt));

    // Asynchronous reset after the third byte of a record.
    step(8'h55, 1'b1, 1'b1);
    step(8'h11, 1'b1, 1'b1);
    step(8'h55, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_rec",   64'(bus.out_rec),   64'd0);
    chk("arst_err",       64'(bus.err),       64'd0);
    chk("arst_rec_count", 64'(bus.rec_count), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_rec(40'h54_DE_AD_BE_EF, 1'b1);
    chk("arst_new_valid", 64'(bus.out_valid), 64'd1);
    chk("arst_new_rec",   64'(bus.out_rec),   64'(REC2));
    step(8'h00, 1'b0, 1'b1);
    chk("arst_new_cnt", 64'(bus.rec_count), 64'd1);

    // Counter wrap: 17 records on a 4-bit counter read back as 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_rec(40'h55_11_55_AA_55, 1'b1);
      step(8'h00, 1'b0, 1'b1);
    end
    chk("wrap_cnt", 64'(bus.rec_count), 64'd1);

    // Random phase: bursts of varying density exercise tags, stalls and timeouts.
    pv = 90;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(2))
          0:       pv = 90;
          1:       pv = 50;
          default: pv = 4;
        endcase
      end
      d = 8'($urandom);
      if ($urandom_range(1) == 1) d[7:1] = TB_TAG;
      step(d, $urandom_range(99) < pv, $urandom_range(99) < 60);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
